parking_occupancy_counter: RTL
==============================

# parking_occupancy_counter

Multi-lane successor to the single-gate car counter. Each of LANES gates carries an outer sensor A and an inner sensor B. The block does three things:
- debounces every sensor on a shared tick;
- decodes entry/exit direction per lane;
- keeps a saturating occupancy count with FULL/EMPTY flags and reject/underflow reporting.

It sits between the raw sensor pins and the LED/display logic.

## Interface
- LANES, 2, number of gates (1..8)
- CNT_W, 8, occupancy counter width
- CAPACITY, 200, maximum occupancy (must be <= 2^CNT_W-1)
- TICK_DIV, 12000, CLK cycles per debounce sample tick (1 kHz at 12 MHz)
- DEB_N, 8, consecutive equal samples required to accept a sensor level
- CLK  in  1  system clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- SENS_A  in  LANES  raw outer sensors, 1 = beam blocked
- SENS_B  in  LANES  raw inner sensors, 1 = beam blocked
- COUNT  out  CNT_W  current occupancy
- FULL  out  1  COUNT == CAPACITY
- EMPTY  out  1  COUNT == 0
- IN_PULSE  out  LANES  one-cycle pulse per completed entry, per lane
- OUT_PULSE  out  LANES  one-cycle pulse per completed exit, per lane
- REJECT  out  1  one-cycle pulse: entries in a cycle exceeded remaining capacity
- UNDERFLOW  out  1  one-cycle pulse: exits in a cycle exceeded current count

## Operation
- Reset (async assert, sync release) puts the block in this state:
  - COUNT=0, EMPTY=1, FULL=0, all pulses 0;
  - tick divider 0;
  - debounced levels 0 and sample counters 0;
  - all lane FSMs in IDLE.
- Tick: a divider counts 0..TICK_DIV-1 and asserts tick for one cycle at wrap.
- Debounce, per sensor:
  - on each tick the raw level is compared with the debounced level;
  - a differing level increments a counter, an equal level clears it;
  - when the counter reaches DEB_N, the debounced level flips and the counter clears.
- Lane FSM, evaluated every CLK on the debounced (a,b):
  - IDLE: (1,0) -> IN1; (0,1) -> OUT1; (1,1) -> ERR.
  - IN1: (1,1) -> IN2; (0,0) -> IDLE.
  - IN2: (0,1) -> IN3; (1,0) -> IN1.
  - IN3: (0,0) -> IDLE and fire IN_PULSE; (1,1) -> IN2.
  - OUT1/OUT2/OUT3 mirror IN1/IN2/IN3 with a and b swapped; OUT3 -> IDLE fires OUT_PULSE.
  - Any input not listed holds the state, except (0,0), which always returns to IDLE with no pulse.
  - ERR: wait for (0,0), then IDLE, no pulse.
- Counter: every cycle, nin = popcount(IN_PULSE) and nout = popcount(OUT_PULSE).
  - Compute t = COUNT + nin - nout in signed CNT_W+4 bits.
  - t > CAPACITY: COUNT = CAPACITY, REJECT = 1.
  - t < 0: COUNT = 0, UNDERFLOW = 1.
  - Otherwise COUNT = t.
  - Simultaneous entries and exits on different lanes net out before clamping. Example: COUNT=CAPACITY, one in and one out gives COUNT unchanged with no REJECT.
- FULL and EMPTY are registered, derived from the next COUNT, and never both 1 (CAPACITY >= 1).

## Timing
- Debounce latency from a clean raw edge to the debounced level change is DEB_N ticks, within one tick period of jitter. A glitch shorter than DEB_N ticks is never accepted.
- Lane pulses are registered:
  - IN_PULSE/OUT_PULSE assert in the cycle after the debounced (0,0) arrives in IN3/OUT3;
  - they last exactly one cycle.
- COUNT, FULL, EMPTY, REJECT and UNDERFLOW update one cycle after the pulses (2 cycles after the final debounced edge).
- Reset asserted mid-traversal discards the partial passage. No pulse follows release.

## Structure
- Package parking_pkg holds:
  - lane state enum: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERR (3 bits);
  - a popcount function;
  - a signed width constant CNT_W+4.
- Sub-module lane_direction: one lane's two debouncers plus its FSM.
  - Inputs: CLK, RST_N, tick, raw a/b.
  - Outputs: in_pulse, out_pulse.
  - Instantiated LANES times in a generate loop.
- Tick divider and counter/clamp logic live in the top.

## Test plan
Benches use TICK_DIV=4, DEB_N=3.
- Lane 0 full entry sequence A, AB, B, none, each held 5 ticks -> one IN_PULSE[0], COUNT 0->1, EMPTY falls.
- Entry then exit on lane 1 -> OUT_PULSE[1], COUNT back to 0, EMPTY=1.
- Both lanes enter in the same cycle from COUNT=CAPACITY-1 -> COUNT=CAPACITY, FULL=1, REJECT one cycle.
- COUNT=CAPACITY, lane 0 entry and lane 1 exit in the same cycle -> COUNT=CAPACITY, no REJECT.
- Exit at COUNT=0 -> UNDERFLOW pulse, COUNT stays 0.
- Abort and noise cases on raw A:
  - A, AB, A, none -> no pulse;
  - a 2-tick glitch -> debounced level unchanged;
  - RST_N low during IN2 -> all outputs at reset values, no pulse after release.

Source files
------------

// File: rtl/parking_occupancy_counter_pkg.sv
// Shared types and helpers for the multi-lane parking occupancy counter.
package parking_pkg;

    // Per-lane passage tracker states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IN1  = 3'd1,
        IN2  = 3'd2,
        IN3  = 3'd3,
        OUT1 = 3'd4,
        OUT2 = 3'd5,
        OUT3 = 3'd6,
        ERR  = 3'd7
    } lane_state_e;

    // Upper bound on gates; popcount always works on this width
    localparam int MAX_LANES   = 8;
    // Headroom bits so COUNT + nin - nout can never wrap before clamping
    localparam int SUM_GUARD_W = 4;

    // Signed width used for the unclamped occupancy sum
    function automatic int sum_w(input int cnt_w);
        return cnt_w + SUM_GUARD_W;
    endfunction

    // Number of set bits in a lane pulse vector
    function automatic logic [3:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/parking_occupancy_counter_if.sv
// Sensor inputs and occupancy outputs of the parking counter.
interface parking_occupancy_counter_if #(
    parameter int LANES = 2,
    parameter int CNT_W = 8
);
    logic [LANES-1:0] sens_a;
    logic [LANES-1:0] sens_b;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic [LANES-1:0] in_pulse;
    logic [LANES-1:0] out_pulse;
    logic             reject;
    logic             underflow;

    // Sensor side: drives the beams, observes the occupancy
    modport master (
        output sens_a, sens_b,
        input  count, full, empty, in_pulse, out_pulse, reject, underflow
    );

    // Counter side
    modport slave (
        input  sens_a, sens_b,
        output count, full, empty, in_pulse, out_pulse, reject, underflow
    );
endinterface

// File: rtl/parking_occupancy_counter_lane_direction.sv
// One gate: synchronise and debounce sensors A/B, then decode passage direction.
module lane_direction
    import parking_pkg::*;
#(
    parameter int DEB_N = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw_a,
    input  logic raw_b,
    output logic in_pulse,
    output logic out_pulse
);
    localparam int CW = $clog2(DEB_N + 1);

    // Bit 0 carries sensor A, bit 1 carries sensor B
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         lvl_q, lvl_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    lane_state_e        state_q, state_d;
    logic               in_q, in_d, out_q, out_d;
    logic [1:0]         ab_s;

    // Two-flop synchroniser for the asynchronous beam sensors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {raw_b, raw_a};
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a level is accepted after DEB_N consecutive differing samples
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (tick) begin
                if (sync2_q[i] != lvl_q[i]) begin
                    if (cnt_q[i] == CW'(DEB_N - 1)) begin
                        lvl_d[i] = ~lvl_q[i];
                        cnt_d[i] = {CW{1'b0}};
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_d[i] = {CW{1'b0}};
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Debounced levels and sample counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 2'b00;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign ab_s = {lvl_q[0], lvl_q[1]};  // {a, b}

    // Direction FSM; (0,0) always returns to IDLE and completes IN3/OUT3
    always_comb begin
        state_d = state_q;
        in_d    = 1'b0;
        out_d   = 1'b0;
        if (ab_s == 2'b00) begin
            state_d = IDLE;
            in_d    = (state_q == IN3);
            out_d   = (state_q == OUT3);
        end else begin
            case (state_q)
                IDLE: begin
                    case (ab_s)
                        2'b10:   state_d = IN1;
                        2'b01:   state_d = OUT1;
                        2'b11:   state_d = ERR;
                        default: state_d = IDLE;
                    endcase
                end
                IN1:     state_d = (ab_s == 2'b11) ? IN2 : IN1;
                IN2: begin
                    case (ab_s)
                        2'b01:   state_d = IN3;
                        2'b10:   state_d = IN1;
                        default: state_d = IN2;
                    endcase
                end
                IN3:     state_d = (ab_s == 2'b11) ? IN2 : IN3;
                OUT1:    state_d = (ab_s == 2'b11) ? OUT2 : OUT1;
                OUT2: begin
                    case (ab_s)
                        2'b10:   state_d = OUT3;
                        2'b01:   state_d = OUT1;
                        default: state_d = OUT2;
                    endcase
                end
                OUT3:    state_d = (ab_s == 2'b11) ? OUT2 : OUT3;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register and registered one-cycle direction pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            in_q    <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    assign in_pulse  = in_q;
    assign out_pulse = out_q;

endmodule

// File: rtl/parking_occupancy_counter.sv
// Multi-lane parking occupancy counter: debounce tick, per-lane decoders,
// saturating occupancy count with FULL/EMPTY and reject/underflow pulses.
module parking_occupancy_counter
    import parking_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int CNT_W    = 8,
    parameter int CAPACITY = 200,
    parameter int TICK_DIV = 12000,
    parameter int DEB_N    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    parking_occupancy_counter_if.slave  bus
);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = sum_w(CNT_W);

    logic [DW-1:0]        div_q, div_d;
    logic                 tick_s;
    logic [LANES-1:0]     in_pulse_s, out_pulse_s;
    logic [3:0]           nin_s, nout_s;
    logic signed [SW-1:0] t_s;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d, empty_q, empty_d;
    logic                 reject_q, reject_d, underflow_q, underflow_d;

    // Debounce sample tick: one cycle at each wrap of the divider
    always_comb begin
        tick_s = (div_q == DW'(TICK_DIV - 1));
        if (tick_s) begin
            div_d = {DW{1'b0}};
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // Tick divider register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= {DW{1'b0}};
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_direction #(.DEB_N(DEB_N)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick_s),
            .raw_a    (bus.sens_a[g]),
            .raw_b    (bus.sens_b[g]),
            .in_pulse (in_pulse_s[g]),
            .out_pulse(out_pulse_s[g])
        );
    end

    // Net entries against exits, then clamp to 0..CAPACITY
    always_comb begin
        nin_s       = popcount(MAX_LANES'(in_pulse_s));
        nout_s      = popcount(MAX_LANES'(out_pulse_s));
        t_s         = $signed(SW'(count_q)) + $signed(SW'(nin_s)) - $signed(SW'(nout_s));
        reject_d    = 1'b0;
        underflow_d = 1'b0;
        if (t_s > $signed(SW'(CAPACITY))) begin
            count_d  = CNT_W'(CAPACITY);
            reject_d = 1'b1;
        end else if (t_s < $signed({SW{1'b0}})) begin
            count_d     = {CNT_W{1'b0}};
            underflow_d = 1'b1;
        end else begin
            count_d = t_s[CNT_W-1:0];
        end
        full_d  = (count_d == CNT_W'(CAPACITY));
        empty_d = (count_d == {CNT_W{1'b0}});
    end

    // Occupancy count, status flags and event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= {CNT_W{1'b0}};
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            reject_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            reject_q    <= reject_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.reject    = reject_q;
    assign bus.underflow = underflow_q;
    assign bus.in_pulse  = in_pulse_s;
    assign bus.out_pulse = out_pulse_s;

endmodule
